npc_commutation_sequencer: RTL and testbench
============================================

NPC_COMMUTATION_SEQUENCER -- requirements
Module: npc_commutation_sequencer

Interface
REQ-001 SHALL have parameter TDELAY_WIDTH, default 8, giving the dead-time counter and tdead port width.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1; one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port en, input, 1, leg enable; 0 forces all gates off.
REQ-005 SHALL have port state_req, input, 2, requested leg state: PP=0, ZZ=1, NN=2; 3 is invalid.
REQ-006 SHALL have port tdead, input, TDELAY_WIDTH, dead time in clk cycles.
REQ-007 SHALL have port gate, output, 4, registered gate drives {S4,S3,S2,S1}, bit0=S1.
REQ-008 SHALL have port state_out, output, 2, current stable leg state (PP/ZZ/NN encoding); holds the last stable value during dead time.
REQ-009 SHALL have port busy, output, 1, high while in any dead-time or off-state sequence.
REQ-010 SHALL have port req_err, output, 1, one-cycle flag for an invalid request.

Function
REQ-011 SHALL implement FSM states OFF, DT_OZ, ST_P, ST_Z, ST_N, DT_PZ, DT_ZP, DT_ZN, DT_NZ.
REQ-012 SHALL drive gates per state: OFF 0000; DT_OZ 0000; ST_P 0011; ST_Z 0110; ST_N 1100; DT_PZ and DT_ZP 0010; DT_ZN and DT_NZ 0100.
REQ-013 SHALL register gate, so gate reflects the FSM state entered at the same edge.
REQ-014 SHALL load the dead-time counter with max(tdead,1) on entry to any DT_* state; tdead=0 behaves as 1.
REQ-015 SHALL sample tdead only on DT_* entry; changes mid-count have no effect.
REQ-016 SHALL decrement the counter each cycle in DT_* and exit when it reaches 1, so each DT_* state lasts exactly max(tdead,1) cycles.
REQ-017 SHALL transition OFF->DT_OZ when en=1, then DT_OZ->ST_Z on expiry.
REQ-018 SHALL transition ST_P->DT_PZ when req is ZZ or NN; DT_PZ->ST_Z on expiry.
REQ-019 SHALL transition ST_Z->DT_ZP when req=PP, ST_Z->DT_ZN when req=NN; DT_ZP->ST_P and DT_ZN->ST_N on expiry.
REQ-020 SHALL transition ST_N->DT_NZ when req is ZZ or PP; DT_NZ->ST_Z on expiry.
REQ-021 SHALL never move P<->N directly: P->N passes through ST_Z, held for at least 1 cycle, with req re-sampled there.
REQ-022 SHALL sample state_req only in ST_* states; requests during DT_*/OFF are ignored.
REQ-023 SHALL hold the current ST_* state when req equals the current state.
REQ-024 SHALL, on req=3 in an ST_* state, hold the state and assert req_err for that cycle; req_err SHALL be 0 otherwise.
REQ-025 SHALL, on en=0 in any state, go to OFF at the next edge (gate 0000); en has priority over all transitions.
REQ-026 SHALL set state_out on ST_* entry: ST_P=0, ST_Z=1, ST_N=2; in OFF and DT_OZ state_out=1.
REQ-027 SHALL set busy=1 in OFF, DT_OZ, and DT_*; busy=0 in ST_*.
REQ-028 SHALL keep the S1/S3 pair and the S2/S4 pair from ever being on together in any state or transition.

Reset
REQ-029 SHALL, on rst=1 (asynchronous), immediately set FSM=OFF, gate=0000, state_out=1, busy=1, req_err=0, counter=0.
REQ-030 SHALL, on rst release with en=1, enter DT_OZ at the first clk edge.
REQ-031 SHALL abort any dead-time count when rst asserts mid-operation, with no gate glitch to an on state.

Verification
REQ-032 SHALL cover start-up: rst release, en=1, tdead=3 -> gate 0000 for 3 cycles, then 0110, state_out=1, busy=0.
REQ-033 SHALL cover ST_Z with req PP, tdead=4 -> gate 0010 for 4 cycles, then 0011, state_out=0.
REQ-034 SHALL cover ST_P with req NN, tdead=2 -> 0010 x2, 0110 x1, 0100 x2, 1100; never 1111/0101/1010.
REQ-035 SHALL cover tdead=0 on ST_N with req ZZ -> gate 0100 for 1 cycle, then 0110.
REQ-036 SHALL cover req=3 in ST_P -> gate stays 0011, req_err=1 for each such cycle.
REQ-037 SHALL cover en=0 and a separate rst pulse mid-DT_ZN -> gate 0000 (next edge for en, immediate for rst); re-enable restarts via DT_OZ.

Source files
------------

// File: rtl/npc_commutation_sequencer.sv
// NPC (three-level neutral-point-clamped) leg commutation sequencer.
// Steps the leg between P, Z and N with dead-time gaps. It never moves P<->N
// directly, and it keeps the complementary switch pairs S1/S3 and S2/S4 from
// ever being on together.
module npc_commutation_sequencer #(
    parameter int TDELAY_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [1:0]              state_req,
    input  logic [TDELAY_WIDTH-1:0] tdead,
    output logic [3:0]              gate,
    output logic [1:0]              state_out,
    output logic                    busy,
    output logic                    req_err
);

    localparam logic [1:0] REQ_P   = 2'd0;
    localparam logic [1:0] REQ_Z   = 2'd1;
    localparam logic [1:0] REQ_N   = 2'd2;
    localparam logic [1:0] REQ_BAD = 2'd3;

    typedef enum logic [3:0] {
        OFF   = 4'd0,
        DT_OZ = 4'd1,
        ST_P  = 4'd2,
        ST_Z  = 4'd3,
        ST_N  = 4'd4,
        DT_PZ = 4'd5,
        DT_ZP = 4'd6,
        DT_ZN = 4'd7,
        DT_NZ = 4'd8
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [TDELAY_WIDTH-1:0] cnt;
    logic                    dt_done;

    // Gate pattern {S4,S3,S2,S1} for each state. Each dead-time state keeps
    // only the inner switch that is common to both ends of the commutation.
    function automatic logic [3:0] gate_of(input state_t s);
        case (s)
            ST_P:           gate_of = 4'b0011;
            ST_Z:           gate_of = 4'b0110;
            ST_N:           gate_of = 4'b1100;
            DT_PZ, DT_ZP:   gate_of = 4'b0010;
            DT_ZN, DT_NZ:   gate_of = 4'b0100;
            default:        gate_of = 4'b0000;
        endcase
    endfunction

    function automatic logic is_dt(input state_t s);
        is_dt = (s == DT_OZ) || (s == DT_PZ) || (s == DT_ZP) ||
                (s == DT_ZN) || (s == DT_NZ);
    endfunction

    function automatic logic is_st(input state_t s);
        is_st = (s == ST_P) || (s == ST_Z) || (s == ST_N);
    endfunction

    // A programmed dead time of zero still gets one cycle of gap.
    function automatic logic [TDELAY_WIDTH-1:0] dt_load(input logic [TDELAY_WIDTH-1:0] t);
        dt_load = (t == '0) ? TDELAY_WIDTH'(1) : t;
    endfunction

    // Next-state rule. en has priority over every transition. P<->N always
    // goes through ST_Z, and the request is sampled again there.
    function automatic state_t next_of(input state_t s, input logic en_i,
                                       input logic [1:0] req, input logic done);
        next_of = s;
        if (!en_i) begin
            next_of = OFF;
        end else begin
            case (s)
                OFF:                 next_of = DT_OZ;
                DT_OZ, DT_PZ, DT_NZ: if (done) next_of = ST_Z;
                DT_ZP:               if (done) next_of = ST_P;
                DT_ZN:               if (done) next_of = ST_N;
                ST_P:  if (req == REQ_Z || req == REQ_N) next_of = DT_PZ;
                ST_Z:  if (req == REQ_P) next_of = DT_ZP;
                       else if (req == REQ_N) next_of = DT_ZN;
                ST_N:  if (req == REQ_Z || req == REQ_P) next_of = DT_NZ;
                default:             next_of = OFF;
            endcase
        end
    endfunction

    assign dt_done   = (cnt <= TDELAY_WIDTH'(1));
    assign state_nxt = next_of(state, en, state_req, dt_done);

    // Sequencer state, dead-time counter and registered outputs. All outputs
    // are decoded from the state entered at this edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= OFF;
            gate      <= 4'b0000;
            state_out <= REQ_Z;
            busy      <= 1'b1;
            req_err   <= 1'b0;
            cnt       <= '0;
        end else begin
            state   <= state_nxt;
            gate    <= gate_of(state_nxt);
            busy    <= !is_st(state_nxt);
            req_err <= en && is_st(state) && (state_req == REQ_BAD);

            if (is_dt(state_nxt) && (state_nxt != state))
                cnt <= dt_load(tdead);
            else if (is_dt(state_nxt))
                cnt <= cnt - TDELAY_WIDTH'(1);
            else
                cnt <= '0;

            case (state_nxt)
                ST_P:             state_out <= REQ_P;
                ST_Z, OFF, DT_OZ: state_out <= REQ_Z;
                ST_N:             state_out <= REQ_N;
                default:          state_out <= state_out;
            endcase
        end
    end

endmodule

// File: tb/tb_npc_commutation_sequencer.sv
// Directed bench for npc_commutation_sequencer. It covers start-up, all leg
// commutations, the zero dead-time case, invalid requests, and aborts by en
// and by rst.
module tb_npc_commutation_sequencer;

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] state_req;
    logic [7:0] tdead;
    logic [3:0] gate;
    logic [1:0] state_out;
    logic       busy;
    logic       req_err;

    int n_total = 0;
    int n_pass  = 0;

    npc_commutation_sequencer #(.TDELAY_WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .state_req (state_req),
        .tdead     (tdead),
        .gate      (gate),
        .state_out (state_out),
        .busy      (busy),
        .req_err   (req_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Advance one rising edge, then settle away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Gate pattern check plus the complementary-pair safety check.
    task automatic chk_gate(input string tag, input int exp);
        chk(tag, int'(gate), exp);
        chk({tag, "_s1s3"}, int'(gate[0] & gate[2]), 0);
        chk({tag, "_s2s4"}, int'(gate[1] & gate[3]), 0);
    endtask

    int exp_pn [6] = '{2, 2, 6, 4, 4, 12};

    initial begin
        rst = 1'b1; en = 1'b0; state_req = 2'd1; tdead = 8'd3;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gate", int'(gate), 0);
        chk("rst_state_out", int'(state_out), 1);
        chk("rst_busy", int'(busy), 1);
        chk("rst_req_err", int'(req_err), 0);

        // Start-up: release reset with the leg enabled and tdead=3.
        rst = 1'b0; en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_gate("start_dt", 0);
            chk("start_dt_busy", int'(busy), 1);
        end
        step();
        chk_gate("start_z", 6);
        chk("start_z_state_out", int'(state_out), 1);
        chk("start_z_busy", int'(busy), 0);

        // ST_Z -> P with tdead=4.
        state_req = 2'd0; tdead = 8'd4;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_gate("zp_dt", 2);
            chk("zp_dt_state_out", int'(state_out), 1);
            chk("zp_dt_busy", int'(busy), 1);
        end
        step();
        chk_gate("zp_p", 3);
        chk("zp_p_state_out", int'(state_out), 0);
        chk("zp_p_busy", int'(busy), 0);

        // Invalid request in ST_P holds the state and flags an error.
        state_req = 2'd3;
        step();
        chk_gate("bad1", 3);
        chk("bad1_req_err", int'(req_err), 1);
        step();
        chk_gate("bad2", 3);
        chk("bad2_req_err", int'(req_err), 1);
        state_req = 2'd0;
        step();
        chk_gate("bad_clr", 3);
        chk("bad_clr_req_err", int'(req_err), 0);

        // P -> N through Z with tdead=2. tdead is changed during the first
        // gap and must not stretch that gap.
        state_req = 2'd2; tdead = 8'd2;
        for (int i = 0; i < 6; i++) begin
            step();
            chk_gate($sformatf("pn_%0d", i), exp_pn[i]);
            chk($sformatf("pn_req_err_%0d", i), int'(req_err), 0);
            if (i == 0) tdead = 8'd7;
            if (i == 2) tdead = 8'd2;
        end
        chk("pn_state_out", int'(state_out), 2);
        chk("pn_busy", int'(busy), 0);

        // tdead=0 from ST_N to ZZ: a single-cycle gap.
        tdead = 8'd0; state_req = 2'd1;
        step();
        chk_gate("nz0_dt", 4);
        chk("nz0_dt_busy", int'(busy), 1);
        chk("nz0_dt_state_out", int'(state_out), 2);
        step();
        chk_gate("nz0_z", 6);
        chk("nz0_z_state_out", int'(state_out), 1);

        // en=0 in the middle of DT_ZN.
        state_req = 2'd2; tdead = 8'd5;
        step();
        chk_gate("en_dt1", 4);
        step();
        chk_gate("en_dt2", 4);
        en = 1'b0;
        step();
        chk_gate("en_off", 0);
        chk("en_off_busy", int'(busy), 1);
        chk("en_off_state_out", int'(state_out), 1);
        en = 1'b1; state_req = 2'd1; tdead = 8'd1;
        step();
        chk_gate("en_re_dt", 0);
        chk("en_re_dt_busy", int'(busy), 1);
        step();
        chk_gate("en_re_z", 6);
        chk("en_re_z_busy", int'(busy), 0);

        // Asynchronous rst pulse in the middle of DT_ZN.
        state_req = 2'd2; tdead = 8'd5;
        step();
        chk_gate("rst_dt1", 4);
        step();
        chk_gate("rst_dt2", 4);
        rst = 1'b1;
        #1;
        chk_gate("rst_async", 0);
        chk("rst_async_busy", int'(busy), 1);
        chk("rst_async_state_out", int'(state_out), 1);
        chk("rst_async_req_err", int'(req_err), 0);
        #1;
        rst = 1'b0; state_req = 2'd1; tdead = 8'd1;
        step();
        chk_gate("rst_re_dt", 0);
        chk("rst_re_dt_busy", int'(busy), 1);
        step();
        chk_gate("rst_re_z", 6);
        chk("rst_re_z_state_out", int'(state_out), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
